// File: rtl/walk_register.sv
// Sticky pedestrian walk-request flag with wait-age, timeout and press-count reporting.
// Every output is registered. A clear from the controller takes priority over a new press.
module walk_register #(
    parameter int AGE_W    = 16,
    parameter int MAX_WAIT = 1000,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WR_Sync,
    input  logic             WR_Reset,
    output logic             WR,
    output logic             WR_Set,
    output logic [AGE_W-1:0] WR_Age,
    output logic             WR_Timeout,
    output logic [CNT_W-1:0] WR_Presses
);

    localparam logic [AGE_W-1:0] LP_MAX_WAIT = AGE_W'(MAX_WAIT);
    localparam logic [AGE_W-1:0] LP_AGE_ONE  = {{(AGE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_wr;
    logic             r_set;
    logic [AGE_W-1:0] r_age;
    logic             r_timeout;
    logic [CNT_W-1:0] r_presses;
    logic             r_sync_d;

    logic             w_rise;
    logic             w_wr_nxt;
    logic             w_set_nxt;
    logic [AGE_W-1:0] w_age_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_presses_nxt;

    function automatic logic [AGE_W-1:0] sat_inc_age(input logic [AGE_W-1:0] v);
        return (&v) ? v : v + LP_AGE_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + LP_CNT_ONE;
    endfunction

    always_comb begin
        w_rise        = WR_Sync & ~r_sync_d;
        w_wr_nxt      = r_wr;
        w_set_nxt     = 1'b0;
        w_age_nxt     = r_age;
        w_timeout_nxt = 1'b0;
        w_presses_nxt = r_presses;
        if (WR_Reset) begin
            w_wr_nxt      = 1'b0;
            w_age_nxt     = '0;
            w_presses_nxt = '0;
        end else begin
            if (!r_wr && WR_Sync) begin
                w_wr_nxt  = 1'b1;
                w_set_nxt = 1'b1;
                w_age_nxt = '0;
            end else if (r_wr) begin
                w_age_nxt = sat_inc_age(r_age);
            end
            if (w_rise) begin
                w_presses_nxt = sat_inc_cnt(r_presses);
            end
            // Timeout is derived from the age being loaded so both change on the same edge.
            w_timeout_nxt = w_wr_nxt && (w_age_nxt >= LP_MAX_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr      <= 1'b0;
            r_set     <= 1'b0;
            r_age     <= '0;
            r_timeout <= 1'b0;
            r_presses <= '0;
            r_sync_d  <= 1'b0;
        end else begin
            r_wr      <= w_wr_nxt;
            r_set     <= w_set_nxt;
            r_age     <= w_age_nxt;
            r_timeout <= w_timeout_nxt;
            r_presses <= w_presses_nxt;
            // Tracks the button even during a clear, so a held button is not a new edge afterwards.
            r_sync_d  <= WR_Sync;
        end
    end

    assign WR         = r_wr;
    assign WR_Set     = r_set;
    assign WR_Age     = r_age;
    assign WR_Timeout = r_timeout;
    assign WR_Presses = r_presses;

endmodule

// File: tb/tb_walk_register.sv
// Bench for walk_register: three parameter sets driven by one stimulus stream and
// compared each cycle against an unbounded-integer reference model.
module tb_walk_register;

    localparam int NI = 3;
    localparam int AW[NI] = '{16, 3, 16};
    localparam int MW[NI] = '{8, 5, 1000};
    localparam int CW[NI] = '{4, 4, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic WR_Sync = 1'b0;
    logic WR_Reset = 1'b0;

    logic        o0_wr, o0_set, o0_to;
    logic [15:0] o0_age;
    logic [3:0]  o0_pr;
    logic        o1_wr, o1_set, o1_to;
    logic [2:0]  o1_age;
    logic [3:0]  o1_pr;
    logic        o2_wr, o2_set, o2_to;
    logic [15:0] o2_age;
    logic [1:0]  o2_pr;

    walk_register #(.AGE_W(16), .MAX_WAIT(8), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .WR_Sync(WR_Sync), .WR_Reset(WR_Reset),
        .WR(o0_wr), .WR_Set(o0_set), .WR_Age(o0_age), .WR_Timeout(o0_to), .WR_Presses(o0_pr));
    walk_register #(.AGE_W(3), .MAX_WAIT(5), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .WR_Sync(WR_Sync), .WR_Reset(WR_Reset),
        .WR(o1_wr), .WR_Set(o1_set), .WR_Age(o1_age), .WR_Timeout(o1_to), .WR_Presses(o1_pr));
    walk_register #(.AGE_W(16), .MAX_WAIT(1000), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .WR_Sync(WR_Sync), .WR_Reset(WR_Reset),
        .WR(o2_wr), .WR_Set(o2_set), .WR_Age(o2_age), .WR_Timeout(o2_to), .WR_Presses(o2_pr));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: plain integers, saturation applied only when reading out.
    bit m_pend[NI];
    int m_age[NI];
    int m_cnt[NI];
    bit m_setf[NI];
    bit m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update(input bit s, input bit clr, input bit rn);
        for (int i = 0; i < NI; i++) begin
            if (!rn) begin
                m_pend[i] = 0; m_age[i] = 0; m_cnt[i] = 0; m_setf[i] = 0;
            end else if (clr) begin
                m_pend[i] = 0; m_age[i] = 0; m_cnt[i] = 0; m_setf[i] = 0;
            end else begin
                m_setf[i] = 0;
                if (!m_pend[i] && s) begin
                    m_pend[i] = 1; m_age[i] = 0; m_setf[i] = 1;
                end else if (m_pend[i]) begin
                    m_age[i] = m_age[i] + 1;
                end
                if (s && !m_prev) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_prev = rn ? s : 1'b0;
    endtask

    task automatic check_inst(input int i, input logic wr, input logic set,
                              input logic [31:0] age, input logic to, input logic [31:0] pr);
        int amax, cmax, eage, ecnt;
        amax = (1 << AW[i]) - 1;
        cmax = (1 << CW[i]) - 1;
        eage = (m_age[i] > amax) ? amax : m_age[i];
        ecnt = (m_cnt[i] > cmax) ? cmax : m_cnt[i];
        check($sformatf("u%0d.WR", i), {31'b0, wr}, {31'b0, m_pend[i]});
        check($sformatf("u%0d.WR_Set", i), {31'b0, set}, {31'b0, m_setf[i]});
        check($sformatf("u%0d.WR_Age", i), age, eage);
        check($sformatf("u%0d.WR_Timeout", i), {31'b0, to},
              (m_pend[i] && eage >= MW[i]) ? 32'd1 : 32'd0);
        check($sformatf("u%0d.WR_Presses", i), pr, ecnt);
    endtask

    task automatic step(input bit s, input bit clr, input bit rn);
        WR_Sync  = s;
        WR_Reset = clr;
        rst_n    = rn;
        @(posedge clk);
        model_update(s, clr, rn);
        cyc++;
        #1;
        check_inst(0, o0_wr, o0_set, {16'b0, o0_age}, o0_to, {28'b0, o0_pr});
        check_inst(1, o1_wr, o1_set, {29'b0, o1_age}, o1_to, {28'b0, o1_pr});
        check_inst(2, o2_wr, o2_set, {16'b0, o2_age}, o2_to, {30'b0, o2_pr});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1);
    endtask

    initial begin
        m_prev = 0;
        for (int i = 0; i < NI; i++) begin
            m_pend[i] = 0; m_age[i] = 0; m_cnt[i] = 0; m_setf[i] = 0;
        end

        // Reset held for three cycles, then idle.
        for (int k = 0; k < 3; k++) step(0, 0, 0);
        idle(5);

        // Single pulse, then hold 50 cycles: age runs past MAX_WAIT and saturates in u1.
        step(1, 0, 1);
        idle(50);

        // One-cycle clear while pending.
        step(0, 1, 1);
        idle(2);

        // Press and clear in the same cycle, then pulses under a held clear.
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(1, 1, 1);
        step(0, 1, 1);
        step(1, 1, 1);
        step(0, 1, 1);
        idle(3);

        // Five separate pulses: one set, presses saturate at 3 in u2.
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 1);
            step(0, 0, 1);
        end
        step(0, 1, 1);

        // Button held 10 cycles, then cleared while still held and released from clear.
        for (int k = 0; k < 10; k++) step(1, 0, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        for (int k = 0; k < 4; k++) step(1, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        step(0, 1, 1);

        // Long wait to reach the default timeout in u2.
        step(1, 0, 1);
        idle(1010);

        // Reset in the middle of a pending request.
        step(0, 0, 0);
        idle(3);
        step(1, 0, 1);
        idle(4);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            bit s, c, r;
            s = ($urandom_range(0, 99) < 35);
            c = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 199) != 0);
            step(s, c, r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/walk_register.md
# walk_register

Pedestrian walk-request register for the traffic light controller. It captures a synchronized walk-button request (`WR_Sync`) into a sticky flag `WR`. The flag holds until the controller FSM serves the walk phase and asserts `WR_Reset`. The block also reports request age, a timeout flag and a press count, so the FSM can prioritise long-waiting pedestrians.

## Interface
Parameters:
- `AGE_W`, default 16: width of the wait-age counter.
- `MAX_WAIT`, default 1000: age in cycles at which `WR_Timeout` asserts. Must satisfy 1 ≤ `MAX_WAIT` ≤ 2^`AGE_W`−1.
- `CNT_W`, default 4: width of the press counter.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `WR_Sync` in 1: walk-button request, already synchronized to `clk`; level-sensitive.
- `WR_Reset` in 1: clear request from the FSM; active-high, synchronous.
- `WR` out 1: walk request pending (sticky).
- `WR_Set` out 1: one-cycle pulse on the cycle `WR` goes 0→1.
- `WR_Age` out `AGE_W`: cycles elapsed since `WR` was set, saturating.
- `WR_Timeout` out 1: asserted while `WR` = 1 and `WR_Age` ≥ `MAX_WAIT`.
- `WR_Presses` out `CNT_W`: rising edges of `WR_Sync` counted since the last clear, saturating.

## Operation
- Priority at each rising edge of `clk`, highest first: `rst_n`=0, then `WR_Reset`=1, then `WR_Sync`=1, then hold.
- Reset (`rst_n`=0):
  - `WR`, `WR_Set`, `WR_Age`, `WR_Timeout`, `WR_Presses` all go to 0.
  - The internal `WR_Sync` delay register also goes to 0.
- Clear (`WR_Reset`=1, `rst_n`=1):
  - `WR`, `WR_Age` and `WR_Presses` go to 0.
  - `WR_Set` is 0.
  - A press arriving in the same cycle is dropped. Clear dominates, so the FSM may hold `WR_Reset` high for the whole walk phase and all presses during that time are ignored.
- Set (`WR_Sync`=1, `WR_Reset`=0, `WR`=0):
  - `WR` goes to 1 and `WR_Age` goes to 0.
  - `WR_Set`=1 for exactly that one cycle.
- Pending (`WR`=1, no clear):
  - `WR_Age` increments by 1 each cycle and saturates at all-ones (no wrap).
  - Further `WR_Sync` activity does not retrigger `WR_Set` and does not reset `WR_Age`.
- Press counting:
  - A rising edge is a cycle with `WR_Sync`=1 and previous-cycle `WR_Sync`=0.
  - Each rising edge not blocked by clear or reset increments `WR_Presses`, saturating at 2^`CNT_W`−1.
  - The edge that sets `WR` counts as the first press.
- Held button: a `WR_Sync` that stays high sets `WR` once and counts as one press. If it is still high when `WR_Reset` drops, `WR` sets again on the first cycle after the clear, and that counts as a new press only if a rising edge occurs.
- `WR_Timeout` is a registered output. It updates on the same edge as the `WR_Age` value it reflects, and is forced to 0 by clear and reset.
- All outputs are registered; there are no combinational input→output paths.

## Timing
- Latency from `WR_Sync` to `WR` is 1 cycle: `WR_Sync` sampled high at edge N gives `WR`=1 after edge N.
- `WR_Reset` to `WR`=0 is also 1 cycle.
- `WR_Age` reads 0 in the first cycle `WR` is high, then 1, 2, and so on.
- `WR_Timeout` rises at the same edge where `WR_Age` becomes `MAX_WAIT`, i.e. `MAX_WAIT` cycles after the set edge.
- A one-cycle `WR_Sync` pulse is sufficient to register a request.
- Reset asserted mid-request clears everything on the next edge. After reset releases, the block waits for a new `WR_Sync`.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release, keep `WR_Sync`=0 → all outputs stay 0.
- Single pulse: `WR_Sync`=1 for 1 cycle at edge N → `WR`=1 from N onward; `WR_Set`=1 only in that cycle; `WR_Presses`=1; `WR` holds for 50 cycles with no further input.
- Age and timeout with `MAX_WAIT`=8:
  - Set, then wait → `WR_Age` counts 0..8 and `WR_Timeout` rises when `WR_Age`=8.
  - With `AGE_W`=3, `WR_Age` saturates at 7 (never wraps to 0). `MAX_WAIT`=8 is invalid there, so use `MAX_WAIT`=5; `WR_Timeout` then stays 1.
- Clear: `WR_Reset`=1 for 1 cycle while pending → `WR`, `WR_Age`, `WR_Timeout` and `WR_Presses` are 0 on the next cycle.
- Simultaneous events and held clear:
  - `WR_Sync`=1 and `WR_Reset`=1 in the same cycle → `WR` stays 0.
  - Pulse `WR_Sync` while `WR_Reset` is held high → still 0.
- Press counting with `CNT_W`=2:
  - 5 separate pulses → `WR_Presses` saturates at 3, and `WR_Set` pulses only once.
  - A `WR_Sync` held high for 10 cycles → `WR_Presses`=1.
